// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU and PC-source
// codes, FSM states and the decoded-instruction bundle.
package cpu_ctrl_pkg;

    // Opcode map, low four bits of the instruction opcode
    localparam logic [3:0] OP_JAL  = 4'h0;
    localparam logic [3:0] OP_JALR = 4'h1;
    localparam logic [3:0] OP_BEQ  = 4'h2;
    localparam logic [3:0] OP_BLE  = 4'h3;
    localparam logic [3:0] OP_LB   = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SB   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_AND  = 4'hA;
    localparam logic [3:0] OP_OR   = 4'hB;
    localparam logic [3:0] OP_ADDI = 4'hC;
    localparam logic [3:0] OP_SUBI = 4'hD;
    localparam logic [3:0] OP_ANDI = 4'hE;
    localparam logic [3:0] OP_ORI  = 4'hF;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    // Next-PC source select
    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_BR   = 2'b01;
    localparam logic [1:0] PCSRC_JAL  = 2'b10;
    localparam logic [1:0] PCSRC_JALR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_JUMP   = 3'd0,
        CLS_BRANCH = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_ALU    = 3'd4
    } instr_class_e;

    // variant distinguishes the pair members: jalr vs jal, ble vs beq, word vs byte
    typedef struct packed {
        instr_class_e cls;
        logic [2:0]   aluop;
        logic         alucsrc;
        logic         memc;
        logic         variant;
        logic         illegal;
    } dec_t;

endpackage

// File: rtl/multicycle_control_unit_op_decode.sv
// Purely combinational opcode classifier feeding the control FSM.
module op_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] op,
    output dec_t            dec
);

    logic upper_set;

    // Any opcode bit above [3:0] marks the instruction illegal
    if (OP_W > 4) begin : g_wide
        assign upper_set = |op[OP_W-1:4];
    end else begin : g_narrow
        assign upper_set = 1'b0;
    end

    // Map the low opcode bits to class, ALU control and access size
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned, which would infer a latch.
        dec         = '0;
        dec.variant = op[0];
        dec.illegal = upper_set;
        case (op[3:0])
            OP_JAL, OP_JALR: begin
                dec.cls   = CLS_JUMP;
                dec.aluop = ALU_ADD;
            end
            OP_BEQ, OP_BLE: begin
                dec.cls   = CLS_BRANCH;
                dec.aluop = ALU_SUB;
            end
            // Odd memory opcodes (lw/sw) are the 2-byte accesses
            OP_LB, OP_LW: begin
                dec.cls     = CLS_LOAD;
                dec.aluop   = ALU_ADD;
                dec.alucsrc = 1'b1;
                dec.memc    = op[0];
            end
            OP_SB, OP_SW: begin
                dec.cls     = CLS_STORE;
                dec.aluop   = ALU_ADD;
                dec.alucsrc = 1'b1;
                dec.memc    = op[0];
            end
            OP_ADD:  begin dec.cls = CLS_ALU; dec.aluop = ALU_ADD; end
            OP_SUB:  begin dec.cls = CLS_ALU; dec.aluop = ALU_SUB; end
            OP_AND:  begin dec.cls = CLS_ALU; dec.aluop = ALU_AND; end
            OP_OR:   begin dec.cls = CLS_ALU; dec.aluop = ALU_OR;  end
            OP_ADDI: begin dec.cls = CLS_ALU; dec.aluop = ALU_ADD; dec.alucsrc = 1'b1; end
            OP_SUBI: begin dec.cls = CLS_ALU; dec.aluop = ALU_SUB; dec.alucsrc = 1'b1; end
            OP_ANDI: begin dec.cls = CLS_ALU; dec.aluop = ALU_AND; dec.alucsrc = 1'b1; end
            OP_ORI:  begin dec.cls = CLS_ALU; dec.aluop = ALU_OR;  dec.alucsrc = 1'b1; end
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with
// a variable-latency memory and keeps a sticky error for timeouts/illegal ops.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W        = 4,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    input  logic               neg,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               wmem,
    output logic               memc,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         PCsrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               alucsrc,
    output logic               m2reg,
    output logic               wreg,
    output logic               jal,
    output logic               instr_done,
    output logic               err
);

    localparam int              CNT_W       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic              timed_out;
    dec_t              dec;

    op_decode #(.OP_W(OP_W)) u_op_decode (
        .op  (op_q),
        .dec (dec)
    );

    assign timed_out = (wait_cnt_q == TIMEOUT_CNT);
    assign err       = err_q;

    // Next-state, wait counter and Mealy datapath controls for the current phase
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_cnt_d = '0;      // any cycle not spent waiting leaves the counter cleared
        err_d      = err_q;
        mem_req    = 1'b0;
        wmem       = 1'b0;
        memc       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        PCsrc      = PCSRC_SEQ;
        ALUOp      = '0;
        alucsrc    = 1'b0;
        m2reg      = 1'b0;
        wreg       = 1'b0;
        jal        = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                if (timed_out) begin
                    err_d      = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    mem_req = 1'b1;
                    memc    = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        op_d    = op;
                        state_d = S_DECODE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end

            // Illegal opcodes retire here as a NOP so no write strobe ever fires
            S_DECODE: begin
                if (dec.illegal) begin
                    err_d      = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                ALUOp   = ALUOP_W'(dec.aluop);
                alucsrc = dec.alucsrc;
                case (dec.cls)
                    CLS_BRANCH: begin
                        pc_we      = dec.variant ? (zero | neg) : zero;
                        PCsrc      = PCSRC_BR;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    CLS_JUMP: begin
                        pc_we      = 1'b1;
                        PCsrc      = dec.variant ? PCSRC_JALR : PCSRC_JAL;
                        wreg       = 1'b1;
                        jal        = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = S_MEM;
                    default:             state_d = S_WB;
                endcase
            end

            S_MEM: begin
                if (timed_out) begin
                    err_d      = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    mem_req = 1'b1;
                    wmem    = (dec.cls == CLS_STORE);
                    memc    = dec.memc;
                    if (mem_ready) begin
                        if (dec.cls == CLS_STORE) begin
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end

            S_WB: begin
                wreg       = 1'b1;
                m2reg      = (dec.cls == CLS_LOAD);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State registers; async reset returns to IDLE so every control drops at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge values, independent of statement order.
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: a trace model builds the expected per-cycle control
// vector for each instruction from the opcode rules and memory latencies.
module tb_multicycle_control_unit;

    localparam int OP_W        = 5;
    localparam int MEM_TIMEOUT = 15;

    localparam int PH_IDLE    = 0;
    localparam int PH_FETCH   = 1;
    localparam int PH_DECODE  = 2;
    localparam int PH_EXEC    = 3;
    localparam int PH_MEM     = 4;
    localparam int PH_WB      = 5;
    localparam int PH_TIMEOUT = 6;

    typedef struct packed {
        logic       mem_req;
        logic       wmem;
        logic       memc;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       alucsrc;
        logic       m2reg;
        logic       wreg;
        logic       jal;
        logic       instr_done;
        logic       err;
    } obs_t;

    typedef struct {
        logic            mem_ready;
        logic [OP_W-1:0] op;
        logic            zero;
        logic            neg;
        obs_t            exp;
        obs_t            mask;
        int              ph;
    } step_t;

    logic            clk, rst;
    logic [OP_W-1:0] op;
    logic            zero, neg, mem_ready;
    logic            mem_req, wmem, memc, ir_we, pc_we;
    logic [1:0]      PCsrc;
    logic [2:0]      ALUOp;
    logic            alucsrc, m2reg, wreg, jal, instr_done, err;
    obs_t            act;

    int    n_cmp = 0;
    int    n_bad = 0;
    logic  err_m = 1'b0;
    step_t trace[$];
    int    abort_idx;

    multicycle_control_unit #(.OP_W(OP_W), .ALUOP_W(3), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .neg(neg), .mem_ready(mem_ready),
        .mem_req(mem_req), .wmem(wmem), .memc(memc), .ir_we(ir_we), .pc_we(pc_we),
        .PCsrc(PCsrc), .ALUOp(ALUOp), .alucsrc(alucsrc), .m2reg(m2reg), .wreg(wreg),
        .jal(jal), .instr_done(instr_done), .err(err)
    );

    assign act = {mem_req, wmem, memc, ir_we, pc_we, PCsrc, ALUOp, alucsrc,
                  m2reg, wreg, jal, instr_done, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string ph_name(input int p);
        case (p)
            PH_IDLE:   return "idle";
            PH_FETCH:  return "fetch";
            PH_DECODE: return "decode";
            PH_EXEC:   return "exec";
            PH_MEM:    return "mem";
            PH_WB:     return "wb";
            default:   return "timeout";
        endcase
    endfunction

    // {aluop, immediate} straight from the opcode table; jumps are masked out
    function automatic logic [3:0] alu_ctl(input logic [3:0] o);
        case (o)
            4'h2, 4'h3:             return 4'b001_0;
            4'h4, 4'h5, 4'h6, 4'h7: return 4'b000_1;
            4'h8: return 4'b000_0;
            4'h9: return 4'b001_0;
            4'hA: return 4'b010_0;
            4'hB: return 4'b011_0;
            4'hC: return 4'b000_1;
            4'hD: return 4'b001_1;
            4'hE: return 4'b010_1;
            4'hF: return 4'b011_1;
            default: return 4'b000_0;
        endcase
    endfunction

    // A cycle with random don't-care inputs and an all-quiet expectation
    function automatic step_t new_step(input int ph);
        step_t s;
        s.mem_ready = 1'($urandom);
        s.op        = OP_W'($urandom);
        s.zero      = 1'($urandom);
        s.neg       = 1'($urandom);
        s.exp       = '0;
        s.exp.err   = err_m;
        s.mask      = '1;
        s.ph        = ph;
        return s;
    endfunction

    // Expected cycle trace of one instruction, starting in FETCH
    task automatic build_trace(input logic [OP_W-1:0] opc, input int fwait, input int mwait,
                               input logic z, input logic n);
        step_t      s;
        logic [3:0] o  = opc[3:0];
        logic [3:0] ac = alu_ctl(opc[3:0]);
        bit         is_store = (o == 4'h6) || (o == 4'h7);
        trace.delete();
        abort_idx = -1;
        for (int i = 0; i < fwait && i < MEM_TIMEOUT; i++) begin
            s = new_step(PH_FETCH);
            s.mem_ready = 1'b0;
            s.exp.mem_req = 1'b1; s.exp.memc = 1'b1;
            trace.push_back(s);
        end
        if (fwait >= MEM_TIMEOUT) begin
            s = new_step(PH_TIMEOUT);
            s.exp.instr_done = 1'b1;
            trace.push_back(s);
            err_m = 1'b1;
            return;
        end
        s = new_step(PH_FETCH);
        s.mem_ready = 1'b1; s.op = opc;
        s.exp.mem_req = 1'b1; s.exp.memc = 1'b1; s.exp.ir_we = 1'b1; s.exp.pc_we = 1'b1;
        trace.push_back(s);
        s = new_step(PH_DECODE);
        if ((opc >> 4) != 0) begin
            s.exp.instr_done = 1'b1;
            trace.push_back(s);
            err_m = 1'b1;
            return;
        end
        trace.push_back(s);
        s = new_step(PH_EXEC);
        s.exp.aluop = ac[3:1]; s.exp.alucsrc = ac[0];
        if (o <= 4'h1) begin
            s.mask.aluop = '0; s.mask.alucsrc = 1'b0;
            s.exp.pc_we = 1'b1; s.exp.pcsrc = (o == 4'h0) ? 2'b10 : 2'b11;
            s.exp.wreg = 1'b1; s.exp.jal = 1'b1; s.exp.instr_done = 1'b1;
            trace.push_back(s);
        end else if (o <= 4'h3) begin
            s.zero = z; s.neg = n;
            s.exp.pcsrc = 2'b01;
            s.exp.pc_we = (o == 4'h2) ? z : (z | n);
            s.exp.instr_done = 1'b1;
            trace.push_back(s);
        end else if (o <= 4'h7) begin
            trace.push_back(s);
            abort_idx = trace.size();
            for (int i = 0; i < mwait && i < MEM_TIMEOUT; i++) begin
                s = new_step(PH_MEM);
                s.mem_ready = 1'b0;
                s.exp.mem_req = 1'b1; s.exp.wmem = is_store; s.exp.memc = o[0];
                trace.push_back(s);
            end
            if (mwait >= MEM_TIMEOUT) begin
                s = new_step(PH_TIMEOUT);
                s.exp.instr_done = 1'b1;
                trace.push_back(s);
                err_m = 1'b1;
                return;
            end
            s = new_step(PH_MEM);
            s.mem_ready = 1'b1;
            s.exp.mem_req = 1'b1; s.exp.wmem = is_store; s.exp.memc = o[0];
            s.exp.instr_done = is_store;
            trace.push_back(s);
            if (!is_store) begin
                s = new_step(PH_WB);
                s.exp.wreg = 1'b1; s.exp.m2reg = 1'b1; s.exp.instr_done = 1'b1;
                trace.push_back(s);
            end
        end else begin
            trace.push_back(s);
            s = new_step(PH_WB);
            s.exp.wreg = 1'b1; s.exp.instr_done = 1'b1;
            trace.push_back(s);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; outputs settle 1 time unit later
    task automatic apply_step(input step_t s);
        @(negedge clk);
        mem_ready = s.mem_ready;
        op        = s.op;
        zero      = s.zero;
        neg       = s.neg;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; op = 5'h08; zero = 1'b1; neg = 1'b1;
        err_m = 1'b0;
        #3;
        n_cmp++;
        if (act !== obs_t'(0)) begin
            n_bad++; $display("FAIL reset_held: got %b want %b", act, obs_t'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (act !== obs_t'(0)) begin
            n_bad++; $display("FAIL reset_idle: got %b want %b", act, obs_t'(0));
        end
    endtask

    task automatic test_add();
        build_trace(5'h08, 0, 0, 1'b0, 1'b0);
        n_cmp++;
        if (trace.size() != 4) begin
            n_bad++; $display("FAIL add_length: got %0d cycles want 4", trace.size());
        end
        foreach (trace[i]) begin
            apply_step(trace[i]);
            n_cmp++;
            if ((act & trace[i].mask) !== (trace[i].exp & trace[i].mask)) begin
                n_bad++;
                $display("FAIL add %s#%0d: got %b want %b", ph_name(trace[i].ph), i, act, trace[i].exp);
            end
        end
    endtask

    task automatic test_branch();
        logic [4:0] ops [5] = '{5'h02, 5'h02, 5'h03, 5'h03, 5'h03};
        logic       zs  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       ns  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            build_trace(ops[k], 0, 0, zs[k], ns[k]);
            foreach (trace[i]) begin
                apply_step(trace[i]);
                n_cmp++;
                if ((act & trace[i].mask) !== (trace[i].exp & trace[i].mask)) begin
                    n_bad++;
                    $display("FAIL branch%0d %s#%0d: got %b want %b", k, ph_name(trace[i].ph), i, act, trace[i].exp);
                end
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [4:0] ops [5] = '{5'h05, 5'h04, 5'h07, 5'h06, 5'h00};
        int         fw  [5] = '{0, 1, 3, 14, 2};
        int         mw  [5] = '{2, 0, 14, 1, 0};
        for (int k = 0; k < 5; k++) begin
            build_trace(ops[k], fw[k], mw[k], 1'b0, 1'b0);
            foreach (trace[i]) begin
                apply_step(trace[i]);
                n_cmp++;
                if ((act & trace[i].mask) !== (trace[i].exp & trace[i].mask)) begin
                    n_bad++;
                    $display("FAIL memwait%0d %s#%0d: got %b want %b", k, ph_name(trace[i].ph), i, act, trace[i].exp);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [4:0] ops [4] = '{5'h06, 5'h08, 5'h09, 5'h05};
        int         fw  [4] = '{0, 15, 0, 0};
        int         mw  [4] = '{15, 0, 0, 15};
        for (int k = 0; k < 4; k++) begin
            build_trace(ops[k], fw[k], mw[k], 1'b0, 1'b0);
            foreach (trace[i]) begin
                apply_step(trace[i]);
                n_cmp++;
                if ((act & trace[i].mask) !== (trace[i].exp & trace[i].mask)) begin
                    n_bad++;
                    $display("FAIL timeout%0d %s#%0d: got %b want %b", k, ph_name(trace[i].ph), i, act, trace[i].exp);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [4:0] ops [3] = '{5'h10, 5'h18, 5'h12};
        for (int k = 0; k < 3; k++) begin
            build_trace(ops[k], 0, 0, 1'b1, 1'b1);
            foreach (trace[i]) begin
                apply_step(trace[i]);
                n_cmp++;
                if ((act & trace[i].mask) !== (trace[i].exp & trace[i].mask)) begin
                    n_bad++;
                    $display("FAIL illegal%0d %s#%0d: got %b want %b", k, ph_name(trace[i].ph), i, act, trace[i].exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        build_trace(5'h07, 0, 3, 1'b0, 1'b0);
        for (int i = 0; i <= abort_idx; i++) begin
            apply_step(trace[i]);
            n_cmp++;
            if ((act & trace[i].mask) !== (trace[i].exp & trace[i].mask)) begin
                n_bad++;
                $display("FAIL rst_mid %s#%0d: got %b want %b", ph_name(trace[i].ph), i, act, trace[i].exp);
            end
        end
        rst = 1'b1;
        err_m = 1'b0;
        #1;
        n_cmp++;
        if (act !== obs_t'(0)) begin
            n_bad++; $display("FAIL rst_mid_abort: got %b want %b", act, obs_t'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (act !== obs_t'(0)) begin
            n_bad++; $display("FAIL rst_mid_idle: got %b want %b", act, obs_t'(0));
        end
    endtask

    task automatic test_random();
        logic [OP_W-1:0] o;
        int              fw, mw;
        for (int k = 0; k < 40; k++) begin
            o = OP_W'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) o[OP_W-1] = 1'b1;
            fw = ($urandom_range(0, 19) == 0) ? 15 : int'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       mw = 14;
                1:       mw = 15;
                default: mw = int'($urandom_range(0, 3));
            endcase
            build_trace(o, fw, mw, 1'($urandom), 1'($urandom));
            foreach (trace[i]) begin
                apply_step(trace[i]);
                n_cmp++;
                if ((act & trace[i].mask) !== (trace[i].exp & trace[i].mask)) begin
                    n_bad++;
                    $display("FAIL rand%0d op=%h %s#%0d: got %b want %b", k, o, ph_name(trace[i].ph), i, act, trace[i].exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_illegal();
        test_reset_mid_mem();
        test_add();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
